spi_master_gen: RTL and testbench
=================================

# spi_master_gen

Parametrised, mode-programmable SPI master: the next generation of the team's fixed 16-bit, single-slave, mode-3 ADC SPI master. It adds configurable frame width, SCLK divider, porch length, per-transfer CPOL/CPHA, and one-of-N chip select. It sits between the audio front-end control logic and off-chip converters and codecs. The host starts a transfer with a one-cycle pulse and collects the full-duplex received word on `done`.

## Interface
- `DATA_W`, default 16: bits per frame, legal range 4..32.
- `CLK_DIV`, default 16: clk cycles per SCLK half-period, ≥2.
- `PORCH`, default 16: clk cycles of selected `SS_n` low before the first SCLK edge and after the last SCLK edge, ≥1.
- `NUM_CS`, default 4: number of slave selects, ≥1.
- `CS_W`: local parameter, `max(1, clog2(NUM_CS))`.

Ports (clock and reset first):
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle transfer request.
- `cs_sel`  in  CS_W  slave index, sampled on an accepted `start`.
- `cpol`  in  1  SCLK idle level, sampled on an accepted `start`.
- `cpha`  in  1  0 = sample on leading edge, 1 = sample on trailing edge. Sampled on an accepted `start`.
- `tx_data`  in  DATA_W  word to send, MSB first. Sampled on an accepted `start`.
- `rx_data`  out  DATA_W  last received word, MSB first.
- `busy`  out  1  high while a transfer is in progress.
- `done`  out  1  one-cycle pulse at the end of a transfer.
- `MISO`  in  1  serial data from the slave.
- `MOSI`  out  1  serial data to the slave.
- `SCLK`  out  1  serial clock.
- `SS_n`  out  NUM_CS  active-low slave selects; at most one is low at any time.

## Operation
- Reset values: `rx_data` = 0, `busy` = 0, `done` = 0, `MOSI` = 0, `SCLK` = 0, `SS_n` = all ones. The FSM returns to IDLE. Reset asserted mid-transfer aborts the transfer immediately, with no `done` pulse.
- Accepting a transfer:
  - `start` is accepted only in IDLE and only when `cs_sel` < `NUM_CS`.
  - `start` in any other state, or with an out-of-range `cs_sel`, is ignored with no side effects.
  - On acceptance, `cs_sel`, `cpol`, `cpha` and `tx_data` are latched. Input changes after that point have no effect on the transfer in progress.
- FSM states: IDLE → FRONT_PORCH → TRANSFER → BACK_PORCH → IDLE.
  - IDLE: `SCLK` tracks the live `cpol` input with one cycle of register delay; `MOSI` = 0.
  - FRONT_PORCH lasts `PORCH` cycles. `SCLK` = latched cpol. `MOSI` = tx_sr[MSB].
  - TRANSFER lasts 2·DATA_W·CLK_DIV cycles. `SCLK` toggles on TRANSFER cycle 0 and every `CLK_DIV` cycles after, giving 2·DATA_W edges. Odd-numbered edges are leading edges, even-numbered edges are trailing edges. The last edge restores the latched cpol level.
  - BACK_PORCH lasts `PORCH` cycles. `SCLK` = latched cpol.
  - On exit from BACK_PORCH: deselect, `done` = 1, `rx_data` ← rx_sr, `busy` = 0.
- Data path: tx_sr and rx_sr are both DATA_W wide and both shift left. `MOSI` = tx_sr[DATA_W-1].
  - cpha = 0: MISO is shifted into rx_sr[0] on every leading edge. tx_sr shifts on every trailing edge except the last.
  - cpha = 1: tx_sr shifts on every leading edge except the first. MISO is shifted into rx_sr[0] on every trailing edge.
- Exactly DATA_W bits are sampled per frame; no bit is dropped or duplicated.
- Edges are generated from an internal divider counter, not from edge detection of `SCLK`.

## Timing
- `start` is sampled at edge 0. Cycle 1 is the first FRONT_PORCH cycle: selected `SS_n` low and `busy` high from that cycle.
- Selected `SS_n` stays low for cycles 1 .. 2·PORCH + 2·DATA_W·CLK_DIV.
- `done` is high, `SS_n` all high and `busy` low at cycle L = 2·PORCH + 2·DATA_W·CLK_DIV + 1. With defaults, L = 545.
- `rx_data` changes only in the `done` cycle and holds its value until the next `done`.
- `done` lasts exactly one cycle.
- The `done` cycle counts as IDLE, so a `start` in that cycle is accepted. This gives back-to-back frames with `SS_n` high for exactly one cycle.
- Sampling point relative to the SCLK edge: MISO is registered on the same clk edge at which `SCLK` toggles.

## Test plan
- Defaults, cpol=1, cpha=1, cs_sel=0, tx_data=16'h1800, slave returns 16'h0ABC:
  - 16 rising `SCLK` edges.
  - `MOSI` bits match 16'h1800.
  - `SS_n`=4'b1110 for cycles 1..544.
  - `done` at cycle 545 with `rx_data`=16'h0ABC.
- All four modes, DATA_W=8, CLK_DIV=2, PORCH=1, tx_data=8'hA5, slave echoes through a mode-matched model:
  - `rx_data`=8'hA5 in each mode.
  - Idle `SCLK` level = cpol.
  - Latency = 2+32+1 = 35 cycles.
- `start` pulsed at cycles 10 and 200 during an active transfer:
  - Both are ignored.
  - Exactly one `done`.
  - `rx_data` unchanged except at that `done`.
- `start` in the `done` cycle with cs_sel=3: `SS_n` all high for one cycle, then `SS_n`=4'b0111. Second frame completes normally.
- cs_sel=3 with NUM_CS=3: no select asserted, `busy` stays 0, no `done`.
- `rst_n` dropped at cycle 100 of a transfer: all outputs take their reset values asynchronously, no `done`. A new `start` after release completes normally.

Source files
------------

// File: rtl/spi_master_gen.sv
// spi_master_gen -- mode-programmable SPI master with one-of-N chip select.
//
// A one-cycle `start` in IDLE (with an in-range `cs_sel`) latches the frame
// settings and runs FRONT_PORCH -> TRANSFER -> BACK_PORCH. The full-duplex
// received word appears on `rx_data` together with a one-cycle `done`.
//
// Ports:
//   clk, rst_n       system clock, asynchronous active-low reset
//   start            one-cycle transfer request
//   cs_sel           slave index, latched on an accepted start
//   cpol, cpha       SPI mode, latched on an accepted start
//   tx_data          word to send (MSB first), latched on an accepted start
//   rx_data          last received word, updated only in the done cycle
//   busy             high from the first FRONT_PORCH cycle until done
//   done             one-cycle end-of-transfer pulse
//   MISO/MOSI/SCLK   serial lines
//   SS_n             active-low one-hot slave selects
module spi_master_gen #(
  parameter int DATA_W  = 16,
  parameter int CLK_DIV = 16,
  parameter int PORCH   = 16,
  parameter int NUM_CS  = 4,
  localparam int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              done,
  input  logic              MISO,
  output logic              MOSI,
  output logic              SCLK,
  output logic [NUM_CS-1:0] SS_n
);

  localparam logic [1:0] IDLE        = 2'd0;
  localparam logic [1:0] FRONT_PORCH = 2'd1;
  localparam logic [1:0] TRANSFER    = 2'd2;
  localparam logic [1:0] BACK_PORCH  = 2'd3;

  localparam int CNT_MAX = (PORCH > CLK_DIV) ? PORCH : CLK_DIV;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int EDGE_W  = $clog2(2 * DATA_W + 1);

  localparam logic [CNT_W-1:0]  PORCH_LAST = CNT_W'(PORCH - 1);
  localparam logic [CNT_W-1:0]  DIV_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST  = EDGE_W'(2 * DATA_W);
  localparam logic [CS_W:0]     NUM_CS_V   = (CS_W + 1)'(NUM_CS);

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;        // porch length / SCLK half-period divider
  logic [EDGE_W-1:0] edge_cnt;   // SCLK edges already issued in this frame
  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] rx_sr;
  logic              cpha_q;
  logic [NUM_CS-1:0] ss_dec;

  logic              accept;
  logic              finish;
  logic              do_edge;
  logic [EDGE_W-1:0] edge_num;
  logic              leading;
  logic              first_edge;
  logic              last_edge;
  logic              do_sample;
  logic              do_shift;

  // One-hot active-low decode of the requested slave.
  for (genvar gi = 0; gi < NUM_CS; gi++) begin : g_dec
    assign ss_dec[gi] = (cs_sel != CS_W'(gi));
  end

  assign accept = (state == IDLE) && start && ({1'b0, cs_sel} < NUM_CS_V);
  assign finish = (state == BACK_PORCH) && (cnt == PORCH_LAST);

  // Edge 1 is issued as the front porch ends, so SCLK has already toggled
  // in TRANSFER cycle 0; later edges follow every CLK_DIV cycles.
  assign do_edge = ((state == FRONT_PORCH) && (cnt == PORCH_LAST)) ||
                   ((state == TRANSFER) && (cnt == DIV_LAST) && (edge_cnt != EDGE_LAST));
  assign edge_num   = (state == FRONT_PORCH) ? EDGE_W'(1) : edge_cnt + EDGE_W'(1);
  assign leading    = edge_num[0];
  assign first_edge = (edge_num == EDGE_W'(1));
  assign last_edge  = (edge_num == EDGE_LAST);

  // cpha=0 samples on leading edges, cpha=1 on trailing edges; the shift
  // happens on the opposite edge type, skipping the one that would push a
  // bit before the first sample or after the last.
  assign do_sample = do_edge && (leading ^ cpha_q);
  assign do_shift  = do_edge && (cpha_q ? (leading && !first_edge)
                                        : (!leading && !last_edge));

  assign MOSI = (state != IDLE) ? tx_sr[DATA_W-1] : 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      edge_cnt <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      cpha_q   <= 1'b0;
      SCLK     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rx_data  <= '0;
      SS_n     <= '1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          SCLK <= cpol;
          cnt  <= '0;
          if (accept) begin
            state  <= FRONT_PORCH;
            busy   <= 1'b1;
            cpha_q <= cpha;
            tx_sr  <= tx_data;
            rx_sr  <= '0;
            SS_n   <= ss_dec;
          end
        end
        FRONT_PORCH: begin
          if (cnt == PORCH_LAST) begin
            state    <= TRANSFER;
            cnt      <= '0;
            edge_cnt <= EDGE_W'(1);
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        TRANSFER: begin
          if (cnt == DIV_LAST) begin
            cnt <= '0;
            if (edge_cnt == EDGE_LAST) begin
              state <= BACK_PORCH;
            end else begin
              edge_cnt <= edge_cnt + EDGE_W'(1);
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          if (finish) begin
            state   <= IDLE;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b1;
            rx_data <= rx_sr;
            SS_n    <= '1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
      endcase
      if (do_edge) begin
        SCLK <= ~SCLK;
      end
      if (do_sample) begin
        rx_sr <= {rx_sr[DATA_W-2:0], MISO};
      end
      if (do_shift) begin
        tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_spi_master_gen.sv
// Testbench for spi_master_gen: default-parameter instance, a small fast
// instance (8-bit, CLK_DIV=2, PORCH=1) and a NUM_CS=3 instance, driven
// against a mode-aware SPI slave model with expected values derived from
// frame-level rules (latency formula, select pattern, word echo).
module tb_spi_master_gen;

  localparam int DW = 16, DD = 16, DP = 16;
  localparam int SW = 8,  SD = 2,  SP = 1;
  localparam int D_LAT = 2 * DP + 2 * DW * DD + 1;
  localparam int S_LAT = 2 * SP + 2 * SW * SD + 1;

  logic clk = 1'b0;
  logic rst_n;
  logic miso;

  logic        d_start, d_cpol, d_cpha, d_busy, d_done, d_mosi, d_sclk;
  logic [1:0]  d_cs;
  logic [15:0] d_tx, d_rx;
  logic [3:0]  d_ss;

  logic        s_start, s_cpol, s_cpha, s_busy, s_done, s_mosi, s_sclk;
  logic [1:0]  s_cs;
  logic [7:0]  s_tx, s_rx;
  logic [3:0]  s_ss;

  logic        t_start, t_cpol, t_cpha, t_busy, t_done, t_mosi, t_sclk;
  logic [1:0]  t_cs;
  logic [7:0]  t_tx, t_rx;
  logic [2:0]  t_ss;

  always #5 clk = ~clk;

  spi_master_gen u_def (
    .clk(clk), .rst_n(rst_n), .start(d_start), .cs_sel(d_cs), .cpol(d_cpol),
    .cpha(d_cpha), .tx_data(d_tx), .rx_data(d_rx), .busy(d_busy), .done(d_done),
    .MISO(miso), .MOSI(d_mosi), .SCLK(d_sclk), .SS_n(d_ss)
  );

  spi_master_gen #(.DATA_W(SW), .CLK_DIV(SD), .PORCH(SP), .NUM_CS(4)) u_small (
    .clk(clk), .rst_n(rst_n), .start(s_start), .cs_sel(s_cs), .cpol(s_cpol),
    .cpha(s_cpha), .tx_data(s_tx), .rx_data(s_rx), .busy(s_busy), .done(s_done),
    .MISO(miso), .MOSI(s_mosi), .SCLK(s_sclk), .SS_n(s_ss)
  );

  spi_master_gen #(.DATA_W(SW), .CLK_DIV(SD), .PORCH(SP), .NUM_CS(3)) u_cs3 (
    .clk(clk), .rst_n(rst_n), .start(t_start), .cs_sel(t_cs), .cpol(t_cpol),
    .cpha(t_cpha), .tx_data(t_tx), .rx_data(t_rx), .busy(t_busy), .done(t_done),
    .MISO(miso), .MOSI(t_mosi), .SCLK(t_sclk), .SS_n(t_ss)
  );

  // Currently observed instance: 0 default, 1 small, 2 NUM_CS=3.
  int          cur;
  logic        m_sclk, m_mosi, m_done, m_busy;
  logic [3:0]  m_ss;
  logic [31:0] m_rx;

  always_comb begin
    m_sclk = d_sclk; m_mosi = d_mosi; m_done = d_done; m_busy = d_busy;
    m_ss = d_ss; m_rx = {16'h0, d_rx};
    if (cur == 1) begin
      m_sclk = s_sclk; m_mosi = s_mosi; m_done = s_done; m_busy = s_busy;
      m_ss = s_ss; m_rx = {24'h0, s_rx};
    end else if (cur == 2) begin
      m_sclk = t_sclk; m_mosi = t_mosi; m_done = t_done; m_busy = t_busy;
      m_ss = {1'b1, t_ss}; m_rx = {24'h0, t_rx};
    end
  end

  // SPI slave: counts SCLK edges while selected; odd edges are leading.
  // It samples MOSI on the mode's sampling edge and presents its next bit
  // on the other edge (cpha=0: first bit on select).
  logic [31:0] sl_word, sl_cap;
  logic        sl_cpha, sl_active, sl_prev;
  int          sl_edges, sl_rise, sl_out, sl_w;

  always @(negedge clk) begin
    sl_w = (cur == 0) ? DW : SW;
    if (m_ss == 4'hF) begin
      sl_active = 1'b0;
    end else if (!sl_active) begin
      sl_active = 1'b1;
      sl_edges = 0; sl_rise = 0; sl_out = 0; sl_cap = 32'h0;
      sl_prev = m_sclk;
      if (!sl_cpha) begin
        miso = sl_word[sl_w-1];
        sl_out = 1;
      end
    end else if (m_sclk != sl_prev) begin
      sl_edges++;
      if (m_sclk) sl_rise++;
      if (((sl_edges % 2) == 1) ^ sl_cpha) begin
        sl_cap = {sl_cap[30:0], m_mosi};
      end else if (sl_out < sl_w) begin
        miso = sl_word[sl_w-1-sl_out];
        sl_out++;
      end
      sl_prev = m_sclk;
    end
  end

  int n_pass, n_total;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic launch(input int c, input logic [1:0] cs, input logic pol, input logic pha,
                        input logic [31:0] tx, input logic [31:0] word);
    cur = c; sl_word = word; sl_cpha = pha;
    case (c)
      0: begin d_cs = cs; d_cpol = pol; d_cpha = pha; d_tx = tx[15:0]; d_start = 1'b1; end
      1: begin s_cs = cs; s_cpol = pol; s_cpha = pha; s_tx = tx[7:0]; s_start = 1'b1; end
      default: begin t_cs = cs; t_cpol = pol; t_cpha = pha; t_tx = tx[7:0]; t_start = 1'b1; end
    endcase
    @(posedge clk);
    #1;
    d_start = 1'b0; s_start = 1'b0; t_start = 1'b0;
  endtask

  // Returns at the negedge of the done cycle (lat = 0 if it never came).
  task automatic wait_done(input logic [3:0] exp_ss, output int lat, output int ss_bad,
                           output logic [31:0] rx);
    lat = 0; ss_bad = 0;
    for (int k = 1; k <= 4000; k++) begin
      @(negedge clk);
      if (m_done) begin
        lat = k;
        break;
      end
      if (m_ss !== exp_ss || m_busy !== 1'b1) ss_bad++;
    end
    rx = m_rx;
  endtask

  typedef struct {
    logic       pol;
    logic       pha;
    logic [1:0] cs;
    logic [7:0] tx;
    logic [7:0] word;
    logic [7:0] exp_rx;
    int         exp_lat;
    logic [3:0] exp_ss;
  } vec_t;

  vec_t        vt[12];
  int          lat, ssb, bad, n_done, done_at, rx_bad;
  logic [31:0] rx, prev_rx;

  initial begin
    n_pass = 0; n_total = 0; cur = 0; miso = 1'b0; rst_n = 1'b0;
    sl_word = 32'h0; sl_cpha = 1'b0; sl_active = 1'b0; sl_prev = 1'b0;
    sl_cap = 32'h0; sl_edges = 0; sl_rise = 0; sl_out = 0; sl_w = DW;
    d_start = 0; d_cpol = 0; d_cpha = 0; d_cs = 0; d_tx = 0;
    s_start = 0; s_cpol = 0; s_cpha = 0; s_cs = 0; s_tx = 0;
    t_start = 0; t_cpol = 0; t_cpha = 0; t_cs = 0; t_tx = 0;

    for (int i = 0; i < 12; i++) begin
      if (i < 4) begin
        vt[i].pol = i[1]; vt[i].pha = i[0]; vt[i].cs = 2'(i);
        vt[i].tx = 8'hA5; vt[i].word = 8'hA5;
      end else begin
        vt[i].pol = 1'($urandom_range(0, 1)); vt[i].pha = 1'($urandom_range(0, 1));
        vt[i].cs = 2'($urandom_range(0, 3));
        vt[i].tx = 8'($urandom); vt[i].word = 8'($urandom);
      end
      vt[i].exp_rx  = vt[i].word;
      vt[i].exp_lat = S_LAT;
      vt[i].exp_ss  = 4'hF & ~(4'b0001 << vt[i].cs);
    end

    // Reset values.
    repeat (3) @(negedge clk);
    chk("rst_rx", {d_rx, s_rx, t_rx}, 32'h0);
    chk("rst_flags", {d_busy, d_done, d_mosi, d_sclk, s_busy, s_done, s_mosi, s_sclk,
                      t_busy, t_done, t_mosi, t_sclk}, 32'h0);
    chk("rst_ss", {d_ss, s_ss, t_ss}, 32'h7FF);
    rst_n = 1'b1;

    // Idle SCLK follows live cpol.
    cur = 1; s_cpol = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_sclk_hi", s_sclk, 1'b1);
    s_cpol = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_sclk_lo", s_sclk, 1'b0);

    // Default instance, mode 3.
    launch(0, 2'd0, 1'b1, 1'b1, 32'h1800, 32'h0ABC);
    wait_done(4'b1110, lat, ssb, rx);
    chk("def_lat", lat, D_LAT);
    chk("def_rx", rx, 32'h0ABC);
    chk("def_ss", ssb, 0);
    chk("def_mosi", sl_cap, 32'h1800);
    chk("def_rises", sl_rise, DW);
    chk("def_done_ss", {m_busy, m_ss}, 5'h0F);

    // Table: four modes with echo, then random frames.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      launch(1, vt[i].cs, vt[i].pol, vt[i].pha, {24'h0, vt[i].tx}, {24'h0, vt[i].word});
      wait_done(vt[i].exp_ss, lat, ssb, rx);
      chk($sformatf("v%0d_lat", i), lat, vt[i].exp_lat);
      chk($sformatf("v%0d_rx", i), rx, {24'h0, vt[i].exp_rx});
      chk($sformatf("v%0d_ss", i), ssb, 0);
      chk($sformatf("v%0d_mosi", i), sl_cap, {24'h0, vt[i].tx});
      chk($sformatf("v%0d_rises", i), sl_rise, SW);
      chk($sformatf("v%0d_done_ss", i), {m_busy, m_ss}, 5'h0F);
      @(negedge clk);
      chk($sformatf("v%0d_idle_sclk", i), m_sclk, vt[i].pol);
    end

    // Starts during an active frame are ignored.
    @(negedge clk);
    launch(0, 2'd0, 1'b0, 1'b0, 32'h3C5A, 32'h9966);
    prev_rx = m_rx; n_done = 0; done_at = 0; rx_bad = 0; ssb = 0;
    for (int k = 1; k <= 700; k++) begin
      @(negedge clk);
      if (m_done) begin n_done++; done_at = k; end
      if (m_rx !== prev_rx && !m_done) rx_bad++;
      prev_rx = m_rx;
      if (k < D_LAT && m_ss !== 4'b1110) ssb++;
      if (k >= D_LAT && m_ss !== 4'hF) ssb++;
      if (k == 10 || k == 200) begin
        d_start = 1'b1; d_cs = 2'd2; d_tx = 16'hFFFF; d_cpol = 1'b1; d_cpha = 1'b1;
      end else begin
        d_start = 1'b0;
      end
    end
    chk("ign_ndone", n_done, 1);
    chk("ign_done_at", done_at, D_LAT);
    chk("ign_rx", m_rx, 32'h9966);
    chk("ign_rx_stable", rx_bad, 0);
    chk("ign_ss", ssb, 0);
    chk("ign_mosi", sl_cap, 32'h3C5A);

    // Back-to-back: start in the done cycle.
    @(negedge clk);
    launch(1, 2'd1, 1'b0, 1'b1, 32'h3C, 32'h96);
    wait_done(4'b1101, lat, ssb, rx);
    chk("b2b1_rx", rx, 32'h96);
    chk("b2b_gap_ss", m_ss, 4'hF);
    launch(1, 2'd3, 1'b1, 1'b0, 32'h81, 32'h7E);
    wait_done(4'b0111, lat, ssb, rx);
    chk("b2b2_lat", lat, S_LAT);
    chk("b2b2_ss", ssb, 0);
    chk("b2b2_rx", rx, 32'h7E);
    chk("b2b2_mosi", sl_cap, 32'h81);

    // Out-of-range select on NUM_CS=3, then a legal frame there.
    @(negedge clk);
    launch(2, 2'd3, 1'b0, 1'b0, 32'h55, 32'h11);
    bad = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (m_busy || m_done || m_ss !== 4'hF) bad++;
    end
    chk("cs_oor", bad, 0);
    launch(2, 2'd2, 1'b1, 1'b1, 32'h6B, 32'hD4);
    wait_done(4'b1011, lat, ssb, rx);
    chk("cs3_lat", lat, S_LAT);
    chk("cs3_rx", rx, 32'hD4);
    chk("cs3_ss", ssb, 0);

    // Reset in the middle of a default frame.
    @(negedge clk);
    launch(0, 2'd1, 1'b1, 1'b0, 32'h5AA5, 32'h1234);
    repeat (99) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_rx", d_rx, 16'h0);
    chk("mid_rst_flags", {d_busy, d_done, d_mosi, d_sclk}, 4'h0);
    chk("mid_rst_ss", d_ss, 4'hF);
    n_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (d_done) n_done++;
    end
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (d_done) n_done++;
    end
    chk("mid_rst_nodone", n_done, 0);
    launch(0, 2'd2, 1'b0, 1'b0, 32'h0F0F, 32'hC3C3);
    wait_done(4'b1011, lat, ssb, rx);
    chk("post_rst_lat", lat, D_LAT);
    chk("post_rst_rx", rx, 32'hC3C3);
    chk("post_rst_ss", ssb, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
